// File: rtl/byte_pack_pkg.sv
// Shared types and width helpers for the byte packer.
//   state_t  : FILL (accepting bytes) / FULL (holding a finished word)
//   word_w() : assembled word width, BYTE_W*NBYTES
//   cnt_w()  : width of a counter holding 0..NBYTES
package byte_pack_pkg;

  typedef enum logic {FILL = 1'b0, FULL = 1'b1} state_t;

  localparam int DEF_BYTE_W = 8;
  localparam int DEF_NBYTES = 2;

  function automatic int word_w(input int byte_w, input int nbytes);
    return byte_w * nbytes;
  endfunction

  function automatic int cnt_w(input int nbytes);
    return $clog2(nbytes + 1);
  endfunction

endpackage

// File: rtl/lane_reg_en.sv
// One lane register of the packer: loads data_i when enable=1, holds otherwise.
// Ports: clk, rst (sync, active-high, clears to 0), enable, data_i, data_o.
module lane_reg_en #(
  parameter int BYTE_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [BYTE_W-1:0] data_i,
  output logic [BYTE_W-1:0] data_o
);

  always_ff @(posedge clk) begin
    if (rst)         data_o <= '0;
    else if (enable) data_o <= data_i;
  end

endmodule

// File: rtl/byte_pack_ctrl.sv
// Assembles NBYTES input bytes into one word with valid/ready on both sides.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   in_data/in_valid/in_ready    : byte input handshake
//   clear           : synchronous discard of partial or held word
//   out_data/out_valid/out_ready : word output handshake (lanes concatenated)
//   lane_en         : one-hot strobe of the lane written this cycle
//   fill_cnt        : bytes currently stored, 0..NBYTES
// Build option: define BYTE_PACK_MSB_FIRST_EN to fill from lane NBYTES-1 down
// to lane 0 instead of lane 0 upward. Count and timing are unchanged.
module byte_pack_ctrl
  import byte_pack_pkg::*;
#(
  parameter int BYTE_W = DEF_BYTE_W,
  parameter int NBYTES = DEF_NBYTES
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [BYTE_W-1:0]              in_data,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic                           clear,
  output logic [word_w(BYTE_W,NBYTES)-1:0] out_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [NBYTES-1:0]              lane_en,
  output logic [cnt_w(NBYTES)-1:0]       fill_cnt
);

  localparam int WORD_W = word_w(BYTE_W, NBYTES);
  localparam int CW     = cnt_w(NBYTES);

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt_nxt;
  logic [CW-1:0]   slot;   // logical byte position of the byte loaded now
  logic            load;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= FILL;
      fill_cnt <= '0;
    end else begin
      state    <= state_nxt;
      fill_cnt <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = fill_cnt;
    slot      = fill_cnt;
    load      = 1'b0;
    in_ready  = 1'b0;
    if (!rst) begin
      if (clear) begin
        state_nxt = FILL;
        cnt_nxt   = '0;
      end else begin
        unique case (state)
          FILL: begin
            in_ready = 1'b1;
            if (in_valid) begin
              load    = 1'b1;
              cnt_nxt = fill_cnt + CW'(1);
              if (fill_cnt == CW'(NBYTES - 1)) state_nxt = FULL;
            end
          end
          FULL: begin
            // A byte may enter only in the cycle the held word leaves;
            // it starts the next word at position 0, so no bubble.
            in_ready = out_ready;
            slot     = '0;
            if (out_ready) begin
              state_nxt = FILL;
              if (in_valid) begin
                load    = 1'b1;
                cnt_nxt = CW'(1);
              end else begin
                cnt_nxt = '0;
              end
            end
          end
          default: begin
            state_nxt = FILL;
            cnt_nxt   = '0;
          end
        endcase
      end
    end
  end

  // Map logical position to physical lane.
  always_comb begin
    int sel;
`ifdef BYTE_PACK_MSB_FIRST_EN
    sel = NBYTES - 1 - int'(slot);
`else
    sel = int'(slot);
`endif
    for (int i = 0; i < NBYTES; i++) lane_en[i] = load && (sel == i);
  end

  assign out_valid = (state == FULL);

  logic [NBYTES-1:0][BYTE_W-1:0] lane_q;

  for (genvar g = 0; g < NBYTES; g++) begin : g_lane
    lane_reg_en #(.BYTE_W(BYTE_W)) u_lane (
      .clk    (clk),
      .rst    (rst),
      .enable (lane_en[g]),
      .data_i (in_data),
      .data_o (lane_q[g])
    );
  end

  assign out_data = WORD_W'(lane_q);

endmodule

// File: tb/tb_byte_pack_ctrl.sv
// Scoreboard bench for byte_pack_ctrl: directed scenarios then random traffic.
// A reference model tracks accepted bytes as a list and emits expected words;
// a monitor compares each word the DUT hands off.
module tb_byte_pack_ctrl;

  localparam int BYTE_W = 8;
  localparam int NBYTES = 2;
  localparam int W      = BYTE_W * NBYTES;
  localparam int CW     = $clog2(NBYTES + 1);

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [BYTE_W-1:0] in_data = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic              clear = 1'b0;
  logic [W-1:0]      out_data;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [NBYTES-1:0] lane_en;
  logic [CW-1:0]     fill_cnt;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  byte_pack_ctrl #(.BYTE_W(BYTE_W), .NBYTES(NBYTES)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .clear     (clear),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .lane_en   (lane_en),
    .fill_cnt  (fill_cnt)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model + scoreboard push ----------------
  logic [BYTE_W-1:0] partial[$];
  logic [W-1:0]      hq[$];
  bit                held = 0;
  bit                zero_chk = 0;

  function automatic logic [W-1:0] build_word();
    logic [W-1:0] w = '0;
    for (int k = 0; k < NBYTES; k++) begin
`ifdef BYTE_PACK_MSB_FIRST_EN
      w |= W'(partial[k]) << ((NBYTES - 1 - k) * BYTE_W);
`else
      w |= W'(partial[k]) << (k * BYTE_W);
`endif
    end
    return w;
  endfunction

  always @(negedge clk) begin
    bit               exp_ir;
    bit               acc;
    int               pos;
    int               lane;
    logic [NBYTES-1:0] exp_le;
    #1;
    exp_ir = !rst && !clear && (!held || out_ready);
    acc    = in_valid && exp_ir;
    exp_le = '0;
    if (acc) begin
      pos = held ? 0 : partial.size();
`ifdef BYTE_PACK_MSB_FIRST_EN
      lane = NBYTES - 1 - pos;
`else
      lane = pos;
`endif
      exp_le[lane] = 1'b1;
    end
    chk("in_ready",  64'(in_ready),  64'(exp_ir));
    chk("out_valid", 64'(out_valid), 64'(held));
    chk("fill_cnt",  64'(fill_cnt),  64'(held ? NBYTES : partial.size()));
    chk("lane_en",   64'(lane_en),   64'(exp_le));
    if (zero_chk) begin
      chk("reset_out_data", 64'(out_data), 64'd0);
      zero_chk = 0;
    end
    if (rst || clear) begin
      partial.delete();
      hq.delete();
      held = 0;
      if (rst) zero_chk = 1;
    end else begin
      if (held && out_ready) held = 0;
      if (acc) begin
        partial.push_back(in_data);
        if (partial.size() == NBYTES) begin
          hq.push_back(build_word());
          partial.delete();
          held = 1;
        end
      end
    end
  end

  // ---------------- monitor: pop and compare ----------------
  always @(negedge clk) begin
    if (out_valid) begin
      if (hq.size() == 0) begin
        chk("unexpected_word", 64'(out_data), 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        chk("out_data", 64'(out_data), 64'(hq[0]));
        if (out_ready && !rst && !clear) void'(hq.pop_front());
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic iv, input logic [BYTE_W-1:0] d, input logic ordy,
                       input logic clr = 1'b0, input logic r = 1'b0);
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    clear     = clr;
    rst       = r;
    @(posedge clk);
    #1;
  endtask

  initial begin
    @(posedge clk); #1;
    drive(0, 8'h00, 0, 0, 1);
    drive(0, 8'h00, 0);

    // basic assembly
    drive(1, 8'h34, 1);
    drive(1, 8'h12, 1);
    drive(0, 8'h00, 1);
    drive(0, 8'h00, 1);

    // back-pressure with a byte waiting
    drive(1, 8'hEF, 0);
    drive(1, 8'hBE, 0);
    for (int i = 0; i < 5; i++) drive(1, 8'h77, 0);
    drive(1, 8'h77, 1);
    drive(1, 8'h66, 1);
    drive(0, 8'h00, 1);
    drive(0, 8'h00, 1);

    // streaming
    for (int i = 1; i <= 8; i++) drive(1, BYTE_W'(i), 1);
    drive(0, 8'h00, 1);
    drive(0, 8'h00, 1);

    // clear mid-fill
    drive(1, 8'hAA, 1);
    drive(1, 8'h55, 1, 1);
    drive(1, 8'h11, 1);
    drive(1, 8'h22, 1);
    drive(0, 8'h00, 1);

    // clear while holding, with out_ready high
    drive(1, 8'hC3, 0);
    drive(1, 8'h3C, 0);
    drive(0, 8'h00, 1, 1);
    drive(0, 8'h00, 1);

    // reset while FULL
    drive(1, 8'h5A, 0);
    drive(1, 8'h5A, 0);
    drive(0, 8'h00, 0);
    drive(0, 8'h00, 1, 0, 1);
    drive(1, 8'h9C, 1);
    drive(1, 8'h4D, 1);
    drive(0, 8'h00, 1);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 99) < 70, BYTE_W'($urandom_range(0, 255)),
            $urandom_range(0, 99) < 60, $urandom_range(0, 99) < 3,
            $urandom_range(0, 199) < 1);
    end

    // drain
    for (int i = 0; i < 4; i++) drive(0, 8'h00, 1);
    chk("scoreboard_empty", 64'(hq.size()), 64'd0);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
